// File: rtl/serial_deser_pkg.sv
// Shared types and defaults for the serial deserializer.
package serial_deser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 5;
   localparam int DEFAULT_DIV   = 4;

endpackage

// File: rtl/serial_deser_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 while clr is low, tick is high on the last count.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with IDLE/SHIFT/DONE handshake FSM.
// Optional even-parity bit and parity_err output enabled by SERIAL_DESER_PARITY_EN.
module serial_deser
   import serial_deser_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIV   = DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             start,
   input  logic             shift_r,
   input  logic             ack,
   output logic [WIDTH-1:0] q,
   output logic             valid,
`ifdef SERIAL_DESER_PARITY_EN
   output logic             parity_err,
`endif
   output logic             busy
);

`ifdef SERIAL_DESER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CNTW = $clog2(NBITS + 1);
   localparam logic [CNTW-1:0] LAST_BIT = CNTW'(NBITS - 1);

   state_t           state_q;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] q_q;
   logic [CNTW-1:0]  bit_cnt_q;
   logic             dir_q;
   logic             tick;
`ifdef SERIAL_DESER_PARITY_EN
   logic             parity_err_q;
`endif

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q != SHIFT),
      .tick  (tick)
   );

   always_comb begin
      sr_d = sr_q;
      if (dir_q) begin
         sr_d = {sin, sr_q[WIDTH-1:1]};
      end else begin
         sr_d = {sr_q[WIDTH-2:0], sin};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         q_q          <= '0;
         bit_cnt_q    <= '0;
         dir_q        <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= SHIFT;
                  dir_q     <= shift_r;
                  sr_q      <= '0;
                  bit_cnt_q <= '0;
               end
            end
            SHIFT: begin
               if (tick) begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                  // The parity bit is checked against the data but never shifted in.
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q      <= DONE;
                     q_q          <= sr_q;
                     parity_err_q <= ^{sr_q, sin};
                  end else begin
                     sr_q <= sr_d;
                  end
`else
                  sr_q <= sr_d;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= DONE;
                     q_q     <= sr_d;
                  end
`endif
               end
            end
            DONE: begin
               if (ack) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign q     = q_q;
   assign busy  = (state_q == SHIFT);
   assign valid = (state_q == DONE);
`ifdef SERIAL_DESER_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the data word width in bits (range 2..16).
REQ-002 The block SHALL have parameter DIV, default 4, giving the clocks per bit sample (range 2..2^26).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sin, input, 1 bit: serial data in.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a word, honoured only in IDLE.
REQ-007 The block SHALL have port shift_r, input, 1 bit: 1 = LSB-first (shift right), 0 = MSB-first (shift left); latched at start.
REQ-008 The block SHALL have port ack, input, 1 bit: consumer acknowledge of q.
REQ-009 The block SHALL have port q, output, WIDTH bits: last completed word.
REQ-010 The block SHALL have port valid, output, 1 bit: q holds an unacknowledged word.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in SHIFT.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-013 In IDLE with start=1, the next edge SHALL enter SHIFT, latch shift_r, clear the internal shift register, clear bit_cnt and clear the divider.
REQ-014 In SHIFT, the divider SHALL count 0..DIV-1 and wrap; tick SHALL be one cycle, asserted when the divider equals DIV-1.
REQ-015 On each tick, the shift register SHALL update: LSB-first -> {sin, sr[WIDTH-1:1]}; MSB-first -> {sr[WIDTH-2:0], sin}; bit_cnt then increments.
REQ-016 The tick that samples bit WIDTH SHALL enter DONE, copying the final shift value into q on that edge.
REQ-017 valid SHALL rise exactly WIDTH*DIV cycles after the start-accepting edge.
REQ-018 In DONE, valid=1 and q SHALL be stable; ack=1 SHALL return the FSM to IDLE, with valid low from the next cycle.
REQ-019 q SHALL hold the last word after ack until the next completion.
REQ-020 start SHALL be ignored in SHIFT and DONE; start and ack in the same DONE cycle -> ack honoured, start dropped, and start must be re-asserted in IDLE.
REQ-021 ack outside DONE SHALL have no effect; sin SHALL be don't-care except on tick cycles.
REQ-022 busy SHALL equal (state==SHIFT) and valid SHALL equal (state==DONE), both decoded from registered state.

Reset
REQ-023 Reset asserted SHALL immediately force state=IDLE and q, sr, bit_cnt, divider, latched direction, valid, busy and parity_err all to 0.
REQ-024 Reset mid-SHIFT or mid-DONE SHALL discard the partial or pending word, with no valid pulse.
REQ-025 After reset release, the first start SHALL be honoured on the first clock edge.

Configuration
REQ-026 With SERIAL_DESER_PARITY_EN defined, SHIFT SHALL sample one extra even-parity bit after the data bits, valid SHALL rise (WIDTH+1)*DIV cycles after start, and an output parity_err (1 bit, registered with q, cleared by reset) SHALL be present.
REQ-027 Without SERIAL_DESER_PARITY_EN, there SHALL be no parity sample and no parity_err port.

Structure
REQ-028 Package serial_deser_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the constants DEFAULT_WIDTH=5 and DEFAULT_DIV=4.
REQ-029 The tick divider SHALL be a sub-module tick_gen (clk, reset, clr, tick), parameterised by DIV.

Verification
REQ-030 The bench SHALL check: WIDTH=5, DIV=4, shift_r=0, sin 1,0,1,1,0 -> q=5'b10110, valid exactly 20 cycles after start, busy high for those 20 cycles.
REQ-031 The bench SHALL check: shift_r=1, same sin sequence -> q=5'b01101.
REQ-032 The bench SHALL check: valid held with ack=0 for 50 cycles -> q stable, start pulses ignored; then ack=1 -> IDLE and valid low the next cycle.
REQ-033 The bench SHALL check: reset pulsed after 3 ticks -> all outputs 0, no valid; then a new start -> correct word with 20-cycle latency.
REQ-034 The bench SHALL check: start and ack together in DONE -> returns to IDLE, no new word begins, busy stays 0.
REQ-035 The bench SHALL check, with SERIAL_DESER_PARITY_EN: data 10110 plus parity bit 0 -> valid at 24 cycles with parity_err=1; parity bit 1 -> parity_err=0.
